instr_fetch: RTL and testbench
==============================

# instr_fetch

- Sequencer stage directly upstream of the opcode decoder.
- Holds the program counter and issues in-order read requests to instruction memory over a valid/ready handshake.
- Buffers returned instruction words in a small FIFO.
- Presents `opcode` and `imm` fields to the decoder and datapath with a valid/ready handshake, one instruction per accepted transfer.

## Interface
- `ADDR_W`, 8: instruction address width; the PC wraps modulo 2^ADDR_W.
- `INSTR_W`, 16: instruction word width. `[15:10]` is opcode and `[9:0]` is imm. Must be ≥ 7.
- `FIFO_DEPTH`, 4: instruction buffer entries. Power of two, ≥ 2.
- `clk` in 1: clock. Everything is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: single-cycle pulse that begins fetching at `start_addr`.
- `start_addr` in ADDR_W: first fetch address.
- `imem_req_valid` out 1: a read request is presented.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out ADDR_W: read address, equal to the current PC.
- `imem_rsp_valid` in 1: read data is valid. Responses return in order, ≥ 1 cycle after acceptance, with no backpressure.
- `imem_rsp_data` in INSTR_W: read data.
- `instr_valid` out 1: the FIFO head is presented.
- `instr_ready` in 1: the consumer takes the head.
- `opcode` out 6: head `[INSTR_W-1:INSTR_W-6]`.
- `imm` out INSTR_W-6: head low bits.
- `pc_out` out ADDR_W: address of the presented instruction.
- `busy` out 1: the state is not IDLE or HALT.
- `halted` out 1: the state is HALT.

## Operation
**States:** IDLE, FETCH, DRAIN, HALT.

**Reset:** state IDLE, PC 0, FIFO empty, outstanding count 0. All outputs read 0.

**Transitions:**
- IDLE/HALT + `start`: load PC ← `start_addr`, go to FETCH. `start` in FETCH or DRAIN is ignored.
- FETCH: assert `imem_req_valid` when credit is available, i.e. `outstanding + occupancy − pop < FIFO_DEPTH`, where pop = `instr_valid & instr_ready` this cycle.
  - On accept (`imem_req_valid & imem_req_ready`): PC ← PC+1, wrapping from 2^ADDR_W−1 to 0, and outstanding += 1.
- Response: write `{imem_rsp_data, addr}` into the FIFO and decrement outstanding.
  - An accept and a response in the same cycle leave outstanding unchanged.
  - A push and a pop in the same cycle leave occupancy unchanged. This is legal at full and at empty. A push into an empty FIFO becomes visible the next cycle, with no bypass.
  - Credit accounting guarantees the FIFO never overflows; overflow is an assertion failure.
- DRAIN: entered only with INSTR_FETCH_HALT_EN (see Configuration). No new requests are issued. Outstanding responses are discarded as they arrive, not written. Go to HALT when outstanding == 0 and the FIFO is empty.
- FETCH never self-terminates without the macro; only `rst` stops it.

**Output hold:** `instr_valid`, `opcode`, `imm` and `pc_out` hold stable while `instr_valid & !instr_ready`.

**Request hold:** once asserted, `imem_req_valid` and `imem_addr` hold until accepted. The request is not withdrawn.

## Timing
- `start` at cycle 0 → `imem_req_valid=1` with `imem_addr=start_addr` at cycle 1.
- Response at cycle t → `instr_valid=1` at t+1.
- With 1-cycle memory latency and `instr_ready=1`: first `instr_valid` at cycle 3, then one instruction per cycle sustained.
- Async `rst` mid-operation clears everything immediately. The memory side must be reset in the same domain; responses to pre-reset requests are undefined.

## Configuration
**INSTR_FETCH_HALT_EN defined:**
- A response whose opcode is 6'b111111 is not written to the FIFO.
- That response moves FETCH→DRAIN in the same cycle, so no request is issued in the following cycle.
- Instructions already in the FIFO still drain to the consumer.

**INSTR_FETCH_HALT_EN undefined:**
- 6'b111111 is an ordinary instruction and passes through to the decoder, which treats it as a no-op.
- DRAIN and HALT are unreachable and `halted` is tied 0.

## Structure
- The shared package `cpu_pkg` holds:
  - the opcode localparams (LOADA=1, LOADB=2, ADD=3, SUB=4, AND=5, OR=6, XOR=7, HALT=6'h3F);
  - the `fetch_state_t` enum;
  - the OPCODE_W=6 constant.
- The FIFO is a sub-module, `instr_fifo`: a synchronous, parameterised-width/depth, registered-output FIFO with `push`, `pop`, `full`, `empty` and `count`.
- The FSM, PC and credit counter live in `instr_fetch`.

## Test plan
- **Stream:** reset, `start` with `start_addr=8'h10`, 1-cycle memory returning ADD/SUB/XOR, `instr_ready=1` → opcodes 3, 4, 7 on consecutive cycles from cycle 3, with `pc_out` = 10, 11, 12.
- **Backpressure:** `instr_ready=0` for 10 cycles → exactly FIFO_DEPTH (4) requests issued, `imem_req_valid` drops, and the head stays stable. On release, 4 instructions arrive in order with no loss or duplication.
- **Wrap:** `start_addr=8'hFE` → `imem_addr` sequence FE, FF, 00, 01.
- **Halt (macro on):** program LOADA, LOADB, HALT, ADD with 3-cycle memory latency → LOADA and LOADB delivered, ADD discarded, then `halted=1` and `busy=0`. A second `start` resumes from the new address.
- **Start ignored / random stall:** `start` pulsed during FETCH → PC unaffected. Random `imem_req_ready` and memory latency 1–4 cycles → the delivered sequence matches memory order.
- **Reset mid-op:** assert `rst` with 2 entries buffered → all outputs 0 immediately, and FETCH resumes only after a new `start`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch sequencer states and field widths.
package cpu_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] LOADA = 6'd1;
    localparam logic [OPCODE_W-1:0] LOADB = 6'd2;
    localparam logic [OPCODE_W-1:0] ADD   = 6'd3;
    localparam logic [OPCODE_W-1:0] SUB   = 6'd4;
    localparam logic [OPCODE_W-1:0] AND   = 6'd5;
    localparam logic [OPCODE_W-1:0] OR    = 6'd6;
    localparam logic [OPCODE_W-1:0] XOR   = 6'd7;
    localparam logic [OPCODE_W-1:0] HALT  = 6'h3F;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FETCH,
        FS_DRAIN,
        FS_HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [OPCODE_W-1:0] op);
        return op == HALT;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: synchronous FIFO with register storage; a pushed word
// becomes visible at the head on the cycle after the push, never combinationally.
module instr_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the same cycle, so a push is legal at full alongside a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: PC, credit-limited memory requests, response buffering and
// the decoder-facing handshake. Optional halt/drain behaviour: INSTR_FETCH_HALT_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           start_addr,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INSTR_W-1:0]          imem_rsp_data,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [OPCODE_W-1:0]         opcode,
    output logic [INSTR_W-OPCODE_W-1:0] imm,
    output logic [ADDR_W-1:0]           pc_out,
    output logic                        busy,
    output logic                        halted
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  rsp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic               credit_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic               pop;
    logic               push;
    logic               accept;
    logic               rsp_take;
    logic               rsp_halt;

    // Credit counts words in flight plus words buffered, so every accepted
    // request is guaranteed a FIFO slot when its response returns.
    assign pop         = instr_valid & instr_ready;
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    assign imem_req_valid = (state == FS_FETCH) && credit_ok;
    assign imem_addr      = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (outstanding != '0);

`ifdef INSTR_FETCH_HALT_EN
    assign rsp_halt = is_halt(imem_rsp_data[INSTR_W-1 -: OPCODE_W]);
`else
    assign rsp_halt = 1'b0;
`endif

    assign push = imem_rsp_valid && (state == FS_FETCH) && !rsp_halt;

    // Responses come back in request order, so the address of each returned
    // word is tracked by a second counter rather than stored per request.
    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({imem_rsp_data, rsp_pc}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr_valid = ~fifo_empty;
    assign opcode      = head[ENTRY_W-1 -: OPCODE_W];
    assign imm         = head[ADDR_W +: INSTR_W-OPCODE_W];
    assign pc_out      = head[ADDR_W-1:0];

`ifdef INSTR_FETCH_HALT_EN
    logic halt_q;
    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_IDLE;
            pc          <= '0;
            rsp_pc      <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
`ifdef INSTR_FETCH_HALT_EN
            halt_q      <= 1'b0;
`endif
        end else begin
            if (accept)
                pc <= pc + 1'b1;
            if (imem_rsp_valid)
                rsp_pc <= rsp_pc + 1'b1;
            unique case ({accept, rsp_take})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            unique case (state)
                FS_IDLE, FS_HALT: begin
                    if (start) begin
                        state  <= FS_FETCH;
                        pc     <= start_addr;
                        rsp_pc <= start_addr;
                        busy   <= 1'b1;
`ifdef INSTR_FETCH_HALT_EN
                        halt_q <= 1'b0;
`endif
                    end
                end
                FS_FETCH: begin
`ifdef INSTR_FETCH_HALT_EN
                    if (imem_rsp_valid && rsp_halt)
                        state <= FS_DRAIN;
`endif
                end
                FS_DRAIN: begin
`ifdef INSTR_FETCH_HALT_EN
                    if ((outstanding == '0) && fifo_empty) begin
                        state  <= FS_HALT;
                        busy   <= 1'b0;
                        halt_q <= 1'b1;
                    end
`endif
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && fifo_full && !pop));
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order instruction memory model
// of configurable or random latency and request backpressure.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int ADDR_W     = 8;
    localparam int INSTR_W    = 16;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  start_addr;
    logic               imem_req_valid;
    logic               imem_req_ready = 1'b1;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data = '0;
    logic               instr_valid;
    logic               instr_ready;
    logic [5:0]         opcode;
    logic [9:0]         imm;
    logic [ADDR_W-1:0]  pc_out;
    logic               busy;
    logic               halted;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W     (ADDR_W),
        .INSTR_W    (INSTR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .imm            (imm),
        .pc_out         (pc_out),
        .busy           (busy),
        .halted         (halted)
    );

    logic [INSTR_W-1:0] mem [256];
    int                 errors = 0;
    int                 checks = 0;
    int                 cyc = 0;
    int                 accepts = 0;
    int                 last_due = 0;
    int                 mem_lat = 1;
    bit                 lat_rand = 1'b0;
    bit                 ready_rand = 1'b0;
    logic               ready_level = 1'b1;
    logic [ADDR_W-1:0]  q_addr [$];
    int                 q_due [$];

    function automatic logic [15:0] pat(input logic [7:0] a);
        logic [5:0] op;
        op = {1'b0, a[4:0]} + 6'd1;
        return {op, 2'b00, a};
    endfunction

    // Memory model: records accepted requests at the edge, then presents the
    // oldest due response for the new cycle; responses never reorder.
    always @(posedge clk) begin
        int due;
        cyc = cyc + 1;
        if (!rst && imem_req_valid && imem_req_ready) begin
            due = cyc - 1 + (lat_rand ? int'($urandom_range(1, 4)) : mem_lat);
            if (due <= last_due)
                due = last_due + 1;
            last_due = due;
            q_addr.push_back(imem_addr);
            q_due.push_back(due);
            accepts = accepts + 1;
        end
        #1;
        imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[q_addr[0]];
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] a, input logic rdy);
        start       = s;
        start_addr  = a;
        instr_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        assert (got === exp)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic flushMemory();
        q_addr.delete();
        q_due.delete();
        last_due = cyc;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        flushMemory();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({imem_req_valid, imem_addr, instr_valid, opcode, imm, pc_out, busy, halted});
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] w;
        logic [7:0]  exp_pc;
        int          delivered;
        int          acc0;
        logic [5:0]  stream_op  [3];
        logic [9:0]  stream_imm [3];

        for (int i = 0; i < 256; i++)
            mem[i] = pat(8'(i));
        mem[8'h10] = 16'h0C05;
        mem[8'h11] = 16'h100A;
        mem[8'h12] = 16'h1FFF;
        stream_op[0] = ADD;  stream_imm[0] = 10'h005;
        stream_op[1] = SUB;  stream_imm[1] = 10'h00A;
        stream_op[2] = XOR;  stream_imm[2] = 10'h3FF;

        // Stream: three instructions at one per cycle starting cycle 3.
        resetDut();
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        applyStimulus(1'b1, 8'h10, 1'b1);
        step();
        applyStimulus(1'b0, 8'h10, 1'b1);
        checkOutput("stream_c1_req", 64'({imem_req_valid, imem_addr, busy, instr_valid}), 64'({1'b1, 8'h10, 1'b1, 1'b0}));
        step();
        checkOutput("stream_c2_req", 64'({imem_req_valid, imem_addr, instr_valid}), 64'({1'b1, 8'h11, 1'b0}));
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("stream_instr", 64'({instr_valid, opcode, imm, pc_out}),
                        64'({1'b1, stream_op[k], stream_imm[k], 8'(8'h10 + k)}));
        end

        // Backpressure: credit stops requests at FIFO_DEPTH, head stays put.
        resetDut();
        applyStimulus(1'b1, 8'h20, 1'b0);
        step();
        applyStimulus(1'b0, 8'h20, 1'b0);
        acc0 = accepts;
        step();
        step();
        w = pat(8'h20);
        checkOutput("bp_head_c3", 64'({instr_valid, opcode, imm, pc_out}), 64'({1'b1, w, 8'h20}));
        for (int k = 0; k < 7; k++)
            step();
        checkOutput("bp_accepts", 64'(accepts - acc0), 64'(FIFO_DEPTH));
        checkOutput("bp_req_dropped", 64'({imem_req_valid, imem_addr}), 64'({1'b0, 8'h24}));
        checkOutput("bp_head_c10", 64'({instr_valid, opcode, imm, pc_out}), 64'({1'b1, w, 8'h20}));
        applyStimulus(1'b0, 8'h20, 1'b1);
        for (int k = 0; k < 5; k++) begin
            w = pat(8'(8'h20 + k));
            checkOutput("bp_release", 64'({instr_valid, opcode, imm, pc_out}), 64'({1'b1, w, 8'(8'h20 + k)}));
            step();
        end

        // Wrap, with a start pulse during FETCH that must be ignored.
        resetDut();
        applyStimulus(1'b1, 8'hFE, 1'b1);
        step();
        applyStimulus(1'b0, 8'hFE, 1'b1);
        checkOutput("wrap_addr_c1", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 8'hFE}));
        step();
        checkOutput("wrap_addr_c2", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 8'hFF}));
        applyStimulus(1'b1, 8'h40, 1'b1);
        step();
        applyStimulus(1'b0, 8'h40, 1'b1);
        checkOutput("wrap_addr_c3", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 8'h00}));
        checkOutput("wrap_pc_c3", 64'({instr_valid, pc_out}), 64'({1'b1, 8'hFE}));
        step();
        checkOutput("wrap_addr_c4", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 8'h01}));
        checkOutput("wrap_pc_c4", 64'({instr_valid, pc_out}), 64'({1'b1, 8'hFF}));
        step();
        w = pat(8'h00);
        checkOutput("wrap_pc_c5", 64'({instr_valid, opcode, imm, pc_out}), 64'({1'b1, w, 8'h00}));

        // Random request stalls, memory latency and consumer readiness.
        resetDut();
        ready_rand = 1'b1;
        lat_rand   = 1'b1;
        applyStimulus(1'b1, 8'h80, 1'b0);
        step();
        start     = 1'b0;
        exp_pc    = 8'h80;
        delivered = 0;
        for (int c = 0; c < 2000 && delivered < 24; c++) begin
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid && instr_ready) begin
                w = pat(exp_pc);
                checkOutput("rand_order", 64'({opcode, imm, pc_out}), 64'({w, exp_pc}));
                exp_pc    = exp_pc + 8'd1;
                delivered = delivered + 1;
            end
            step();
        end
        checkOutput("rand_progress", 64'(delivered), 64'd24);
        ready_rand = 1'b0;
        lat_rand   = 1'b0;

        // Asynchronous reset with two entries buffered.
        resetDut();
        applyStimulus(1'b1, 8'h30, 1'b0);
        step();
        applyStimulus(1'b0, 8'h30, 1'b0);
        step();
        step();
        step();
        checkOutput("rstmid_buffered", 64'({instr_valid, pc_out, dut.fifo_count}), 64'({1'b1, 8'h30, 3'd2}));
        rst = 1'b1;
        #1;
        checkOutput("rstmid_outputs", allOutputs(), 64'd0);
        flushMemory();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        checkOutput("rstmid_idle", 64'({imem_req_valid, busy, instr_valid}), 64'd0);
        applyStimulus(1'b1, 8'h50, 1'b1);
        step();
        applyStimulus(1'b0, 8'h50, 1'b1);
        checkOutput("rstmid_restart", 64'({imem_req_valid, imem_addr, busy}), 64'({1'b1, 8'h50, 1'b1}));

`ifdef INSTR_FETCH_HALT_EN
        // Halt: LOADA, LOADB delivered; ADD after HALT is discarded.
        begin
            logic [5:0] got_ops [$];
            mem[8'h60] = 16'h0401;
            mem[8'h61] = 16'h0802;
            mem[8'h62] = 16'hFC00;
            mem[8'h63] = 16'h0C03;
            resetDut();
            mem_lat = 3;
            applyStimulus(1'b1, 8'h60, 1'b1);
            step();
            start = 1'b0;
            for (int c = 0; c < 40 && !halted; c++) begin
                if (instr_valid)
                    got_ops.push_back(opcode);
                step();
            end
            checkOutput("halt_count", 64'(got_ops.size()), 64'd2);
            if (got_ops.size() >= 2) begin
                checkOutput("halt_op0", 64'(got_ops[0]), 64'(LOADA));
                checkOutput("halt_op1", 64'(got_ops[1]), 64'(LOADB));
            end
            checkOutput("halt_state", 64'({halted, busy, instr_valid, imem_req_valid}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
            mem_lat = 1;
            applyStimulus(1'b1, 8'h70, 1'b1);
            step();
            applyStimulus(1'b0, 8'h70, 1'b1);
            checkOutput("halt_resume", 64'({imem_req_valid, imem_addr, busy, halted}), 64'({1'b1, 8'h70, 1'b1, 1'b0}));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
